// File: rtl/soc_system_led_pio_pkg.sv
// Shared register map constants for the LED PIO block with hardware blink.
package soc_system_led_pio_pkg;

   localparam logic [2:0] ADDR_DATA       = 3'd0;
   localparam logic [2:0] ADDR_BLINK_MASK = 3'd1;
   localparam logic [2:0] ADDR_BLINK_DIV  = 3'd2;
   localparam logic [2:0] ADDR_STATUS     = 3'd3;
   localparam logic [2:0] ADDR_OUTSET     = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;

   localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/soc_system_led_pio_blink_timer.sv
// Programmable divider producing the blink phase; half period is div+1 cycles.
module soc_system_led_pio_blink_timer #(
   parameter int DIV_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [DIV_WIDTH-1:0] div,
   input  logic                 div_load,
   output logic                 phase
);

   logic [DIV_WIDTH-1:0] cnt;

   // A divider reload restarts the count but keeps the phase, and wins over a terminal count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (div_load) begin
         cnt <= '0;
      end else if (div == '0) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (cnt == div) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/soc_system_led_pio.sv
// Avalon-MM LED PIO with set/clear aliases and a per-bit hardware blink overlay.
module soc_system_led_pio
   import soc_system_led_pio_pkg::*;
#(
   parameter int               WIDTH       = 10,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               DIV_WIDTH   = 24
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   logic [WIDTH-1:0]     data_reg;
   logic [WIDTH-1:0]     mask_reg;
   logic [DIV_WIDTH-1:0] div_reg;
   logic                 phase;
   logic                 wr_en;
   logic                 div_load;
   logic [31:0]          read_mux;
   logic                 unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign div_load     = wr_en && (address == ADDR_BLINK_DIV);
   assign unused_wdata = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_reg <= RESET_VALUE;
         mask_reg <= '0;
         div_reg  <= '0;
      end else if (wr_en) begin
         case (address)
            ADDR_DATA:       data_reg <= writedata[WIDTH-1:0];
            ADDR_BLINK_MASK: mask_reg <= writedata[WIDTH-1:0];
            ADDR_BLINK_DIV:  div_reg  <= writedata[DIV_WIDTH-1:0];
            ADDR_OUTSET:     data_reg <= data_reg | writedata[WIDTH-1:0];
            ADDR_OUTCLEAR:   data_reg <= data_reg & ~writedata[WIDTH-1:0];
            default:         ;
         endcase
      end
   end

   // Read mux sees pre-write register values, so a same-cycle write is not visible yet.
   always_comb begin
      read_mux = '0;
      case (address)
         ADDR_DATA:       read_mux[WIDTH-1:0]     = data_reg;
         ADDR_BLINK_MASK: read_mux[WIDTH-1:0]     = mask_reg;
         ADDR_BLINK_DIV:  read_mux[DIV_WIDTH-1:0] = div_reg;
         ADDR_STATUS:     read_mux[STATUS_PHASE_BIT] = phase;
         default:         ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
         out_port <= RESET_VALUE;
      end else begin
         readdata <= read_mux;
         out_port <= data_reg ^ (mask_reg & {WIDTH{phase}});
      end
   end

   soc_system_led_pio_blink_timer #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_blink_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .div      (div_reg),
      .div_load (div_load),
      .phase    (phase)
   );

endmodule

// File: tb/tb_soc_system_led_pio.sv
// Directed self-checking bench for soc_system_led_pio: register map, set/clear, blink timing, reset.
module tb_soc_system_led_pio;
   import soc_system_led_pio_pkg::*;

   localparam int WIDTH     = 10;
   localparam int DIV_WIDTH = 24;

   logic             clk        = 1'b0;
   logic             reset_n    = 1'b0;
   logic [2:0]       address    = '0;
   logic             chipselect = 1'b0;
   logic             write_n    = 1'b1;
   logic [31:0]      writedata  = '0;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] out_port;

   int          assertCount = 0;
   int          failCount   = 0;
   logic [31:0] rd;

   always #5 clk = ~clk;

   soc_system_led_pio #(
      .WIDTH       (WIDTH),
      .RESET_VALUE ('0),
      .DIV_WIDTH   (DIV_WIDTH)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Called at a falling edge; the write lands on the following rising edge.
   task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
      address    = addr;
      writedata  = data;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic busRead(input logic [2:0] addr, output logic [31:0] data);
      address = addr;
      @(negedge clk);
      data = readdata;
   endtask

   initial begin
      logic [31:0] expSeqA [5];
      logic [31:0] expSeqB [5];
      expSeqA = '{32'd1, 32'd1, 32'd0, 32'd0, 32'd1};
      expSeqB = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0};

      repeat (3) @(negedge clk);
      checkOutput("reset_out_port", 32'(out_port), 32'h0);
      checkOutput("reset_readdata", readdata, 32'h0);
      reset_n = 1'b1;

      // DATA write on the first edge after release; read returns pre-write value
      applyStimulus(ADDR_DATA, 32'h0000_02A5);
      checkOutput("rd_prewrite_data", readdata, 32'h0);
      checkOutput("out_before_update", 32'(out_port), 32'h0);
      @(negedge clk);
      checkOutput("out_after_write", 32'(out_port), 32'h2A5);
      checkOutput("rd_data_2a5", readdata, 32'h0000_02A5);
      busRead(ADDR_DATA, rd);
      checkOutput("busread_data_2a5", rd, 32'h0000_02A5);

      // OUTSET / OUTCLEAR
      applyStimulus(ADDR_DATA, 32'h0000_000F);
      applyStimulus(ADDR_OUTSET, 32'h0000_0300);
      busRead(ADDR_DATA, rd);
      checkOutput("data_after_outset", rd, 32'h0000_030F);
      busRead(ADDR_OUTSET, rd);
      checkOutput("rd_outset_zero", rd, 32'h0);
      applyStimulus(ADDR_OUTCLEAR, 32'h0000_0003);
      busRead(ADDR_DATA, rd);
      checkOutput("data_after_outclear", rd, 32'h0000_030C);
      busRead(ADDR_OUTCLEAR, rd);
      checkOutput("rd_outclear_zero", rd, 32'h0);

      // Bits above WIDTH are ignored
      applyStimulus(ADDR_OUTSET, 32'hFFFF_FC00);
      busRead(ADDR_DATA, rd);
      checkOutput("outset_upper_ignored", rd, 32'h0000_030C);
      applyStimulus(ADDR_DATA, 32'hFFFF_F0AA);
      busRead(ADDR_DATA, rd);
      checkOutput("data_upper_ignored", rd, 32'h0000_00AA);
      checkOutput("out_port_0aa", 32'(out_port), 32'h0AA);

      // Writes to STATUS and reserved addresses do nothing
      applyStimulus(ADDR_STATUS, 32'hFFFF_FFFF);
      applyStimulus(3'd6, 32'hFFFF_FFFF);
      applyStimulus(3'd7, 32'hFFFF_FFFF);
      busRead(ADDR_DATA, rd);
      checkOutput("ignored_wr_data", rd, 32'h0000_00AA);
      busRead(ADDR_BLINK_MASK, rd);
      checkOutput("ignored_wr_mask", rd, 32'h0);
      busRead(ADDR_BLINK_DIV, rd);
      checkOutput("ignored_wr_div", rd, 32'h0);
      busRead(ADDR_STATUS, rd);
      checkOutput("ignored_wr_status", rd, 32'h0);
      busRead(3'd6, rd);
      checkOutput("rd_reserved6", rd, 32'h0);

      // Blink with div=3: four cycles per half period
      applyStimulus(ADDR_DATA, 32'h0);
      applyStimulus(ADDR_BLINK_MASK, 32'h0000_0001);
      applyStimulus(ADDR_BLINK_DIV, 32'h0000_0003);
      address = ADDR_STATUS;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         checkOutput($sformatf("blink3_out_%0d", k), 32'(out_port), 32'(((k - 1) / 4) % 2));
         checkOutput($sformatf("blink3_status_%0d", k), readdata, 32'(((k - 1) / 4) % 2));
      end

      // Reload divider to 1 while cnt=2 and phase=1
      repeat (2) @(negedge clk);
      applyStimulus(ADDR_BLINK_DIV, 32'h0000_0001);
      checkOutput("rd_prewrite_div", readdata, 32'h0000_0003);
      checkOutput("out_phase_kept", 32'(out_port), 32'h1);
      address = ADDR_STATUS;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput($sformatf("reload_out_%0d", k), 32'(out_port), expSeqA[k]);
         checkOutput($sformatf("reload_status_%0d", k), readdata, expSeqA[k]);
      end

      // Div=0 written while phase=1: phase drops and stays low
      applyStimulus(ADDR_BLINK_DIV, 32'h0);
      address = ADDR_STATUS;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput($sformatf("div0_out_%0d", k), 32'(out_port), expSeqB[k]);
         checkOutput($sformatf("div0_status_%0d", k), readdata, expSeqB[k]);
      end

      // Reset mid-blink with a simultaneous DATA write
      applyStimulus(ADDR_DATA, 32'h0000_00F0);
      applyStimulus(ADDR_BLINK_MASK, 32'h0000_03FF);
      applyStimulus(ADDR_BLINK_DIV, 32'h0000_0001);
      repeat (3) @(negedge clk);
      address    = ADDR_DATA;
      writedata  = 32'h0000_03FF;
      chipselect = 1'b1;
      write_n    = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      checkOutput("out_async_reset", 32'(out_port), 32'h0);
      checkOutput("rd_async_reset", readdata, 32'h0);
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      reset_n    = 1'b1;

      applyStimulus(ADDR_DATA, 32'h0000_0055);
      checkOutput("post_reset_data_zero", readdata, 32'h0);
      busRead(ADDR_BLINK_MASK, rd);
      checkOutput("post_reset_mask", rd, 32'h0);
      busRead(ADDR_BLINK_DIV, rd);
      checkOutput("post_reset_div", rd, 32'h0);
      busRead(ADDR_STATUS, rd);
      checkOutput("post_reset_status", rd, 32'h0);
      busRead(ADDR_DATA, rd);
      checkOutput("first_write_accepted", rd, 32'h0000_0055);
      checkOutput("post_reset_out_port", 32'(out_port), 32'h055);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
